// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory initiator.
// Funct3 encodings, FSM state enum and store byte-enable generation.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } lsu_state_e;

    // Byte lanes touched by an access of the given size at offset a
    function automatic logic [3:0] be_for_size(
        input logic [2:0] funct3,
        input logic [1:0] a
    );
        logic [3:0] be;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << a;
            F3_H, F3_HU: be = a[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: selects the addressed byte/half of a memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_data_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension
    always_comb begin
        byte_sel = mem_data_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = mem_data_i[7:0];
            2'd1:    byte_sel = mem_data_i[15:8];
            2'd2:    byte_sel = mem_data_i[23:16];
            default: byte_sel = mem_data_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            default: data_o = mem_data_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU front end: one byte-addressed load/store at a time onto a word memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [XLEN-1:0]   o_resp_rdata,
    output logic              o_resp_err,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic              o_mem_rw_mode,
    output logic [XLEN-1:0]   o_mem_write_data,
    output logic [3:0]        o_mem_byte_en,
    input  logic [XLEN-1:0]   i_mem_data
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        alo_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic              mem_rw_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [3:0]        mem_be_q;

    logic [1:0]        a_al;
    logic              f3_bad;
    logic              req_err;
    logic [XLEN-1:0]   wdata_rep;
    logic [XLEN-1:0]   load_data;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^i_req_addr[XLEN-1:MEM_AW+2];

    // Request decode: legality, alignment and store lane replication
    always_comb begin
        if (i_req_we)
            f3_bad = (i_req_funct3 != F3_B) && (i_req_funct3 != F3_H)
                  && (i_req_funct3 != F3_W);
        else
            f3_bad = (i_req_funct3 == 3'b011)
                  || (i_req_funct3[2:1] == 2'b11);
        case (i_req_funct3[1:0])
            2'b01:   a_al = {i_req_addr[1], 1'b0};
            2'b10:   a_al = 2'b00;
            default: a_al = i_req_addr[1:0];
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = f3_bad
               || (i_req_funct3[1:0] == 2'b01 && i_req_addr[0])
               || (i_req_funct3[1:0] == 2'b10 && i_req_addr[1:0] != 2'b00);
`else
        req_err = f3_bad;
`endif
        case (i_req_funct3[1:0])
            2'b00:   wdata_rep = {4{i_req_wdata[7:0]}};
            2'b01:   wdata_rep = {2{i_req_wdata[15:0]}};
            default: wdata_rep = i_req_wdata;
        endcase
    end

    lsu_load_align u_align (
        .mem_data_i (i_mem_data),
        .funct3_i   (funct3_q),
        .addr_lo_i  (alo_q),
        .data_o     (load_data)
    );

    // Request/response FSM with registered memory and response outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            alo_q        <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_rw_q     <= 1'b1;
            mem_wdata_q  <= '0;
            mem_be_q     <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        we_q         <= i_req_we;
                        funct3_q     <= i_req_funct3;
                        alo_q        <= a_al;
                        resp_rdata_q <= '0;
                        if (req_err) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            mem_addr_q <= i_req_addr[MEM_AW+1:2];
                            mem_rw_q   <= ~i_req_we;
                            if (i_req_we) begin
                                mem_wdata_q <= wdata_rep;
                                mem_be_q    <= be_for_size(i_req_funct3, a_al);
                            end else begin
                                mem_be_q    <= 4'b1111;
                            end
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        mem_rw_q     <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    resp_rdata_q <= load_data;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                default: begin
                    if (i_resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
            endcase
        end
    end

    assign o_req_ready      = (state_q == IDLE);
    assign o_resp_valid     = resp_valid_q;
    assign o_resp_err       = resp_err_q;
    assign o_resp_rdata     = resp_rdata_q;
    assign o_mem_addr       = mem_addr_q;
    assign o_mem_rw_mode    = mem_rw_q;
    assign o_mem_write_data = mem_wdata_q;
    assign o_mem_byte_en    = mem_be_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a behavioural word memory.
// Honors LSU_MISALIGN_TRAP_EN for the misaligned-store expectations.
module tb_lsu_mem_initiator;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'd0;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b1;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic [9:0]  o_mem_addr;
    logic        o_mem_rw_mode;
    logic [31:0] o_mem_write_data;
    logic [3:0]  o_mem_byte_en;
    logic [31:0] i_mem_data = 32'd0;

    int tests = 0;
    int failed = 0;

    logic [31:0] mem [0:1023];

    int          wr_cnt = 0;
    logic [9:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;

    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;
    int          r_wr;

    lsu_mem_initiator dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_we         (i_req_we),
        .i_req_funct3     (i_req_funct3),
        .i_req_addr       (i_req_addr),
        .i_req_wdata      (i_req_wdata),
        .o_resp_valid     (o_resp_valid),
        .i_resp_ready     (i_resp_ready),
        .o_resp_rdata     (o_resp_rdata),
        .o_resp_err       (o_resp_err),
        .o_mem_addr       (o_mem_addr),
        .o_mem_rw_mode    (o_mem_rw_mode),
        .o_mem_write_data (o_mem_write_data),
        .o_mem_byte_en    (o_mem_byte_en),
        .i_mem_data       (i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous memory: writes while rw_mode = 0, registered read
    always @(posedge i_clk) begin
        if (!o_mem_rw_mode) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_byte_en[b])
                    mem[o_mem_addr][8*b +: 8] <= o_mem_write_data[8*b +: 8];
        end
        i_mem_data <= mem[o_mem_addr];
    end

    // Record every write cycle seen by the memory
    always @(negedge i_clk) begin
        if (!o_mem_rw_mode) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = o_mem_addr;
            wr_be   = o_mem_byte_en;
            wr_data = o_mem_write_data;
        end
    end

    // One request, resp_ready high; returns data, err, latency, writes
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        int n;
        int w0;
        w0 = wr_cnt;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        n = 0;
        while (!o_resp_valid && n < 10) begin
            @(posedge i_clk); #1;
            n++;
        end
        r_data = o_resp_rdata;
        r_err  = o_resp_err;
        r_lat  = n + 1;
        if (n >= 10) begin
            tests++;
            failed++;
            $display("FAIL timeout addr=%h: no response", addr);
        end
        @(posedge i_clk); #1;
        r_wr = wr_cnt - w0;
    endtask

    task automatic test_reset();
        tests++;
        if ({o_mem_rw_mode, o_mem_addr, o_mem_write_data, o_mem_byte_en}
            !== {1'b1, 10'd0, 32'd0, 4'd0}) begin
            failed++;
            $display("FAIL reset_mem: rw=%b a=%h d=%h be=%b", o_mem_rw_mode,
                     o_mem_addr, o_mem_write_data, o_mem_byte_en);
        end
        tests++;
        if ({o_resp_valid, o_resp_rdata, o_resp_err, o_req_ready}
            !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
            failed++;
            $display("FAIL reset_resp: v=%b d=%h e=%b rdy=%b", o_resp_valid,
                     o_resp_rdata, o_resp_err, o_req_ready);
        end
    endtask

    task automatic test_word();
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        tests++;
        if ({r_wr, wr_addr, wr_be, wr_data, r_lat, r_err, r_data}
            !== {32'd1, 10'd4, 4'hF, 32'hDEADBEEF, 32'd2, 1'b0, 32'd0}) begin
            failed++;
            $display("FAIL sw: got n=%0d a=%h be=%b d=%h lat=%0d e=%b r=%h need 1 004 1111 deadbeef 2 0 0",
                     r_wr, wr_addr, wr_be, wr_data, r_lat, r_err, r_data);
        end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        tests++;
        if ({r_data, r_lat, r_err, r_wr} !== {32'hDEADBEEF, 32'd3, 1'b0, 32'd0}) begin
            failed++;
            $display("FAIL lw: got d=%h lat=%0d e=%b w=%0d need deadbeef 3 0 0",
                     r_data, r_lat, r_err, r_wr);
        end
    endtask

    task automatic test_byte();
        run_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
        tests++;
        if ({r_wr, wr_addr, wr_be, wr_data}
            !== {32'd1, 10'd4, 4'b1000, 32'hA5A5A5A5}) begin
            failed++;
            $display("FAIL sb: got n=%0d a=%h be=%b d=%h need 1 004 1000 a5a5a5a5",
                     r_wr, wr_addr, wr_be, wr_data);
        end
        run_req(1'b0, 3'b000, 32'h13, 32'h0);
        tests++;
        if (r_data !== 32'hFFFFFFA5) begin
            failed++;
            $display("FAIL lb: got %h need ffffffa5", r_data);
        end
        run_req(1'b0, 3'b100, 32'h13, 32'h0);
        tests++;
        if (r_data !== 32'h000000A5) begin
            failed++;
            $display("FAIL lbu: got %h need 000000a5", r_data);
        end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        tests++;
        if (r_data !== 32'hA5ADBEEF) begin
            failed++;
            $display("FAIL lw_merge: got %h need a5adbeef", r_data);
        end
    endtask

    task automatic test_half();
        run_req(1'b1, 3'b001, 32'h22, 32'h00008001);
        tests++;
        if ({wr_addr, wr_be, wr_data} !== {10'd8, 4'b1100, 32'h80018001}) begin
            failed++;
            $display("FAIL sh: got a=%h be=%b d=%h need 008 1100 80018001",
                     wr_addr, wr_be, wr_data);
        end
        run_req(1'b0, 3'b001, 32'h22, 32'h0);
        tests++;
        if (r_data !== 32'hFFFF8001) begin
            failed++;
            $display("FAIL lh: got %h need ffff8001", r_data);
        end
        run_req(1'b0, 3'b101, 32'h22, 32'h0);
        tests++;
        if (r_data !== 32'h00008001) begin
            failed++;
            $display("FAIL lhu: got %h need 00008001", r_data);
        end
        // High address bits wrap onto the same word
        run_req(1'b0, 3'b101, 32'h8000_1022, 32'h0);
        tests++;
        if (r_data !== 32'h00008001) begin
            failed++;
            $display("FAIL wrap: got %h need 00008001", r_data);
        end
    endtask

    task automatic test_errors();
        run_req(1'b0, 3'b011, 32'h10, 32'h0);
        tests++;
        if ({r_err, r_lat, r_data, r_wr} !== {1'b1, 32'd1, 32'd0, 32'd0}) begin
            failed++;
            $display("FAIL ld_f3: got e=%b lat=%0d d=%h w=%0d need 1 1 0 0",
                     r_err, r_lat, r_data, r_wr);
        end
        run_req(1'b1, 3'b100, 32'h10, 32'h11111111);
        tests++;
        if ({r_err, r_lat, r_wr} !== {1'b1, 32'd1, 32'd0}) begin
            failed++;
            $display("FAIL st_f3: got e=%b lat=%0d w=%0d need 1 1 0",
                     r_err, r_lat, r_wr);
        end
        tests++;
        if (o_resp_err !== 1'b0) begin
            failed++;
            $display("FAIL err_clear: got %b need 0", o_resp_err);
        end
        run_req(1'b1, 3'b010, 32'h11, 32'h12345678);
`ifdef LSU_MISALIGN_TRAP_EN
        tests++;
        if ({r_err, r_lat, r_data, r_wr} !== {1'b1, 32'd1, 32'd0, 32'd0}) begin
            failed++;
            $display("FAIL sw_mis: got e=%b lat=%0d d=%h w=%0d need 1 1 0 0",
                     r_err, r_lat, r_data, r_wr);
        end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        tests++;
        if (r_data !== 32'hA5ADBEEF) begin
            failed++;
            $display("FAIL mis_keep: got %h need a5adbeef", r_data);
        end
`else
        tests++;
        if ({r_err, r_lat, r_wr, wr_addr, wr_be}
            !== {1'b0, 32'd2, 32'd1, 10'd4, 4'hF}) begin
            failed++;
            $display("FAIL sw_mis: got e=%b lat=%0d w=%0d a=%h be=%b need 0 2 1 004 1111",
                     r_err, r_lat, r_wr, wr_addr, wr_be);
        end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        tests++;
        if (r_data !== 32'h12345678) begin
            failed++;
            $display("FAIL mis_write: got %h need 12345678", r_data);
        end
`endif
    endtask

    task automatic test_backpressure();
        int n;
        int w0;
        i_resp_ready = 1'b0;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b101;
        i_req_addr   = 32'h22;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        n = 0;
        while (!o_resp_valid && n < 10) begin
            @(posedge i_clk); #1;
            n++;
        end
        w0 = wr_cnt;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h40;
        i_req_wdata  = 32'hCAFEF00D;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if ({o_resp_valid, o_resp_rdata, o_req_ready}
                !== {1'b1, 32'h00008001, 1'b0}) begin
                failed++;
                $display("FAIL hold[%0d]: got v=%b d=%h rdy=%b need 1 00008001 0",
                         c, o_resp_valid, o_resp_rdata, o_req_ready);
            end
            @(posedge i_clk); #1;
        end
        i_req_valid  = 1'b0;
        i_resp_ready = 1'b1;
        @(posedge i_clk); #1;
        tests++;
        if ({o_resp_valid, o_req_ready} !== 2'b01) begin
            failed++;
            $display("FAIL release: got v=%b rdy=%b need 0 1",
                     o_resp_valid, o_req_ready);
        end
        repeat (4) @(posedge i_clk);
        #1;
        tests++;
        if ({wr_cnt - w0, 31'd0, o_resp_valid} !== {32'd0, 31'd0, 1'b0}) begin
            failed++;
            $display("FAIL ignored_req: got w=%0d v=%b need 0 0",
                     wr_cnt - w0, o_resp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h30;
        i_req_wdata  = 32'h0BADCAFE;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        tests++;
        if (o_mem_rw_mode !== 1'b0) begin
            failed++;
            $display("FAIL access_rw: got %b need 0", o_mem_rw_mode);
        end
        #1 i_rst = 1'b1;
        #1;
        tests++;
        if ({o_mem_rw_mode, o_req_ready, o_resp_valid, o_mem_addr}
            !== {1'b1, 1'b1, 1'b0, 10'd0}) begin
            failed++;
            $display("FAIL async_rst: got rw=%b rdy=%b v=%b a=%h need 1 1 0 000",
                     o_mem_rw_mode, o_req_ready, o_resp_valid, o_mem_addr);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk); #1;
            if (o_resp_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            failed++;
            $display("FAIL stale_resp: got %0d valid cycles need 0", seen);
        end
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit front end for the RISC-V core. Accepts one byte-addressed load or store at a time from the execute stage and converts it into word-addressed accesses on the data memory port: rw_mode 1 = read, 0 = write, 4-bit byte enables, read data registered one cycle after the read edge.
- Returns aligned, sign- or zero-extended load data, or a store completion, over a valid/ready response channel.

Parameters:
- MEM_AW, 10, word-address width; word address = i_req_addr[MEM_AW+1:2].
- XLEN, 32, data width; fixed at 32.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  request valid
- o_req_ready  out  1  high only in IDLE
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32I size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, LSB-aligned
- o_resp_valid  out  1  response valid; held until i_resp_ready
- i_resp_ready  in  1  response accept
- o_resp_rdata  out  32  extended load data; 0 for stores and errors
- o_resp_err  out  1  illegal funct3 or misaligned access (see Optional Feature)
- o_mem_addr  out  MEM_AW  word address
- o_mem_rw_mode  out  1  1 = read, 0 = write
- o_mem_write_data  out  32  lane-replicated store data
- o_mem_byte_en  out  4  byte lane enables
- i_mem_data  in  32  memory read data, valid the cycle after the read edge

Behaviour:
- Memory outputs are registered.
- o_mem_rw_mode is 0 during exactly one cycle (ACCESS of a store) and 1 at all other times, because the memory writes on every edge while rw_mode = 0.
- Reset values: state IDLE, o_mem_rw_mode = 1, o_mem_addr = 0, o_mem_write_data = 0, o_mem_byte_en = 0, o_resp_valid = 0, o_resp_rdata = 0, o_resp_err = 0.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: o_req_ready = 1. On i_req_valid, capture the request.
  - Legal request: load the memory output registers, go to ACCESS.
  - Error: set o_resp_err = 1 and o_resp_rdata = 0, go straight to RESP. No memory access occurs.
- ACCESS: memory signals are stable for this cycle; the memory samples them at the closing edge.
  - Store: go to RESP, and o_mem_rw_mode returns to 1 at that edge.
  - Load: go to CAPTURE.
- CAPTURE: i_mem_data is valid. Register the extracted load data into o_resp_rdata, go to RESP.
- RESP: o_resp_valid = 1. When i_resp_ready is seen, clear o_resp_valid and o_resp_err and go to IDLE.
- Latency with i_resp_ready tied high, counting from the accept edge (cycle 0): store response at cycle 2, load response at cycle 3, error response at cycle 1. Throughput is one request per 3 or 4 cycles.
- Store lanes (a = addr[1:0]):
  - SB: byte_en = 1 << a; data = four copies of wdata[7:0].
  - SH: byte_en = 0011 if a[1] = 0, else 1100; data = two copies of wdata[15:0].
  - SW: byte_en = 1111; data = wdata.
- Load byte_en is 1111.
- Load extract:
  - LB/LBU: byte a of i_mem_data, sign- or zero-extended.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: full word.
- Address bits above MEM_AW+1 are ignored (wrap).
- Illegal funct3 for a load is 011, 110 or 111. For a store, anything other than 000/001/010 is illegal. Illegal funct3 raises err.
- Reset asserted mid-operation: immediate return to IDLE with reset values. An in-flight store in ACCESS is not guaranteed to complete. No stale response is issued afterwards.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0] = 1 or a word with addr[1:0] != 0 is an error response. No memory access occurs and o_mem_rw_mode stays 1.
- Undefined: low address bits are silently forced to alignment (halfword clears addr[0], word clears addr[1:0]) and the access proceeds normally.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - enum lsu_state_e {IDLE, ACCESS, CAPTURE, RESP}.
  - function be_for_size(funct3, a) returning 4 bits.
- Sub-module lsu_load_align is purely combinational: (i_mem_data, funct3, a) -> 32-bit extended data. It is instantiated once, feeding CAPTURE.

Test Plan:
- Reset, then SW addr 0x10, wdata 0xDEADBEEF -> one ACCESS cycle with o_mem_addr = 4, byte_en = 1111, rw_mode = 0; resp at cycle 2 with err = 0. Then LW 0x10 -> rdata 0xDEADBEEF at cycle 3.
- SB addr 0x13, wdata 0x000000A5 -> byte_en = 1000, write_data = 0xA5A5A5A5. Then LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5; LW 0x10 -> 0xA5ADBEEF.
- SH addr 0x22, wdata 0x8001 -> byte_en = 1100. Then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
- funct3 = 011 load, then SW addr 0x11 (macro on) -> err = 1 at cycle 1, rw_mode never 0, rdata = 0. With macro off, the SW to 0x11 writes word address 4.
- Hold i_resp_ready = 0 for 5 cycles -> o_resp_valid and o_resp_rdata stable, o_req_ready = 0, and a new i_req_valid is ignored.
- Assert i_rst during ACCESS of a store -> rw_mode = 1 asynchronously, state IDLE, no response issued after reset release.
